// File: rtl/ctr_run_arbiter.sv
// Round-robin arbiter sharing one mod-16 / mod-10 count engine among NREQ requesters.
// Optional abort-on-request-drop behaviour is enabled by defining CTR_RUN_ABORT_EN.
module ctr_run_arbiter #(
   parameter int NREQ   = 4,
   parameter int PASS_W = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_mode,
   input  logic [NREQ*PASS_W-1:0]   req_passes,
   output logic [NREQ-1:0]          gnt,
   output logic                     busy,
   output logic [3:0]               Q,
   output logic                     TC,
`ifdef CTR_RUN_ABORT_EN
   output logic                     abort,
`endif
   output logic [NREQ-1:0]          done
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t              state;
   logic [IDX_W-1:0]    rr;
   logic [IDX_W-1:0]    owner;
   logic                mode;
   logic [PASS_W-1:0]   passes;
   logic [PASS_W-1:0]   pass_cnt;
   logic [3:0]          last;

   logic                found;
   logic [IDX_W-1:0]    pick;
   logic [PASS_W-1:0]   pick_passes;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
      if (cur == IDX_W'(NREQ - 1))
         return '0;
      return cur + 1'b1;
   endfunction

   function automatic logic [NREQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
      logic [NREQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   assign last = mode ? 4'd9 : 4'd15;

   // First requester at or above the rr pointer, wrapping; a pass count of 0 runs once.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = rr;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr) + i) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
      pick_passes = req_passes[pick*PASS_W +: PASS_W];
      if (pick_passes == '0)
         pick_passes = PASS_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         Q        <= 4'd0;
         TC       <= 1'b0;
         gnt      <= '0;
         done     <= '0;
         busy     <= 1'b0;
         pass_cnt <= '0;
         passes   <= '0;
         rr       <= '0;
         owner    <= '0;
         mode     <= 1'b0;
`ifdef CTR_RUN_ABORT_EN
         abort    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               Q    <= 4'd0;
               TC   <= 1'b0;
               done <= '0;
`ifdef CTR_RUN_ABORT_EN
               abort <= 1'b0;
`endif
               if (found) begin
                  state    <= RUN;
                  gnt      <= one_hot(pick);
                  owner    <= pick;
                  mode     <= req_mode[pick];
                  passes   <= pick_passes;
                  pass_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
`ifdef CTR_RUN_ABORT_EN
               if (!req[owner]) begin
                  state <= IDLE;
                  Q     <= 4'd0;
                  TC    <= 1'b0;
                  gnt   <= '0;
                  busy  <= 1'b0;
                  abort <= 1'b1;
                  rr    <= next_idx(owner);
               end else
`endif
               if (Q < last) begin
                  Q  <= Q + 4'd1;
                  TC <= ((Q + 4'd1) == last);
               end else if (pass_cnt != passes - 1'b1) begin
                  Q        <= 4'd0;
                  TC       <= 1'b0;
                  pass_cnt <= pass_cnt + 1'b1;
               end else begin
                  state <= FINISH;
                  Q     <= 4'd0;
                  TC    <= 1'b0;
                  done  <= gnt;
                  rr    <= next_idx(owner);
               end
            end
            FINISH: begin
               state <= IDLE;
               done  <= '0;
               gnt   <= '0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ctr_run_arbiter.sv
// Directed bench for ctr_run_arbiter; expected values are hand-derived from the run timing.
module tb_ctr_run_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [3:0]  req_mode;
   logic [11:0] req_passes;
   logic [3:0]  gnt;
   logic        busy;
   logic [3:0]  Q;
   logic        TC;
   logic [3:0]  done;
`ifdef CTR_RUN_ABORT_EN
   logic        abort;
`endif

   int n_vec = 0;
   int n_err = 0;

   ctr_run_arbiter #(.NREQ(4), .PASS_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_mode   (req_mode),
      .req_passes (req_passes),
      .gnt        (gnt),
      .busy       (busy),
      .Q          (Q),
      .TC         (TC),
`ifdef CTR_RUN_ABORT_EN
      .abort      (abort),
`endif
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pass(input int i, input logic [2:0] v);
      req_passes[i*3 +: 3] = v;
   endtask

   function automatic int idx_of(input logic [3:0] g);
      int r;
      r = -1;
      for (int i = 0; i < 4; i++)
         if (g[i]) r = i;
      return r;
   endfunction

   initial begin
      int tc_cnt;
      int order[8];
      int n_ord;
      logic [3:0] prev_gnt;
      logic multi_hot;
      logic q_over;
      logic any_done;
      int wait_cnt;

      reset      = 1'b0;
      req        = '0;
      req_mode   = '0;
      req_passes = '0;
      #12;
      chk("rst_q", Q, 4'd0);
      chk("rst_tc", TC, 1'b0);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_done", done, 4'b0000);
      chk("rst_busy", busy, 1'b0);
      step();
      reset = 1'b1;
      step();

      // single mode-0 run on requester 0
      req = 4'b0001; req_mode = 4'b0000; set_pass(0, 3'd1);
      step();
      chk("m0_gnt", gnt, 4'b0001);
      chk("m0_q0", Q, 4'd0);
      chk("m0_busy", busy, 1'b1);
      tc_cnt = 0;
      for (int k = 1; k <= 15; k++) begin
         step();
         chk("m0_q", Q, k);
         chk("m0_tc", TC, (k == 15));
         chk("m0_nodone", done, 4'b0000);
      end
      step();
      chk("m0_done", done, 4'b0001);
      chk("m0_gnt_done", gnt, 4'b0001);
      chk("m0_q_done", Q, 4'd0);
      req = 4'b0000;
      step();
      chk("m0_done_clr", done, 4'b0000);
      chk("m0_gnt_clr", gnt, 4'b0000);
      chk("m0_busy_clr", busy, 1'b0);

      // mode-1, three passes on requester 2
      req = 4'b0100; req_mode = 4'b0100; set_pass(2, 3'd3);
      step();
      chk("m1_gnt", gnt, 4'b0100);
      tc_cnt = 0;
      for (int k = 1; k <= 29; k++) begin
         step();
         chk("m1_q", Q, k % 10);
         if (TC) tc_cnt++;
         chk("m1_tc", TC, ((k % 10) == 9));
      end
      chk("m1_tc_pulses", tc_cnt, 3);
      set_pass(2, 3'd5);
      step();
      chk("m1_done", done, 4'b0100);
      req = 4'b0000;
      step();
      chk("m1_idle", busy, 1'b0);

      // pass count 0 behaves as one pass
      req = 4'b0010; req_mode = 4'b0010; set_pass(1, 3'd0);
      step();
      chk("p0_gnt", gnt, 4'b0010);
      tc_cnt = 0;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk("p0_q", Q, k);
         if (TC) tc_cnt++;
      end
      chk("p0_tc_pulses", tc_cnt, 1);
      step();
      chk("p0_done", done, 4'b0010);
      req = 4'b0000;
      step();

      // asynchronous reset mid-run
      req = 4'b0001; req_mode = 4'b0000; set_pass(0, 3'd1);
      step();
      chk("rm_gnt", gnt, 4'b0001);
      for (int k = 1; k <= 7; k++) step();
      chk("rm_q7", Q, 4'd7);
      #2;
      reset = 1'b0;
      req   = 4'b0000;
      #1;
      chk("rm_q", Q, 4'd0);
      chk("rm_tc", TC, 1'b0);
      chk("rm_gnt_clr", gnt, 4'b0000);
      chk("rm_busy", busy, 1'b0);
      step();
      reset = 1'b1;
      any_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (done != 4'b0000) any_done = 1'b1;
      end
      chk("rm_no_done", any_done, 1'b0);

      // round robin with all four requesting
      req = 4'b1111; req_mode = 4'b1111;
      for (int i = 0; i < 4; i++) set_pass(i, 3'd1);
      n_ord = 0; prev_gnt = 4'b0000; multi_hot = 1'b0; q_over = 1'b0;
      for (int k = 0; k < 60; k++) begin
         step();
         if ((gnt & (gnt - 4'd1)) != 4'b0000) multi_hot = 1'b1;
         if (Q > 4'd9) q_over = 1'b1;
         if (prev_gnt == 4'b0000 && gnt != 4'b0000 && n_ord < 8) begin
            order[n_ord] = idx_of(gnt);
            n_ord++;
         end
         prev_gnt = gnt;
      end
      chk("rr_count", (n_ord >= 5), 1'b1);
      chk("rr_g0", order[0], 0);
      chk("rr_g1", order[1], 1);
      chk("rr_g2", order[2], 2);
      chk("rr_g3", order[3], 3);
      chk("rr_g4", order[4], 0);
      chk("rr_onehot", multi_hot, 1'b0);
      chk("rr_q_max", q_over, 1'b0);
      req = 4'b0000;
      wait_cnt = 0;
      while (busy && wait_cnt < 50) begin
         step();
         wait_cnt++;
      end
      chk("rr_drain", busy, 1'b0);

`ifdef CTR_RUN_ABORT_EN
      // dropping the grantee's request aborts the run
      step();
      req = 4'b1000; req_mode = 4'b0000; set_pass(3, 3'd1);
      step();
      chk("ab_gnt", gnt, 4'b1000);
      for (int k = 1; k <= 5; k++) step();
      chk("ab_q5", Q, 4'd5);
      req = 4'b0001;
      step();
      chk("ab_abort", abort, 1'b1);
      chk("ab_q", Q, 4'd0);
      chk("ab_gnt_clr", gnt, 4'b0000);
      chk("ab_no_done", done, 4'b0000);
      step();
      chk("ab_abort_clr", abort, 1'b0);
      chk("ab_next_gnt", gnt, 4'b0001);
      chk("ab_no_done3", done, 4'b0000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
